// File: rtl/card_dealer_if.sv
// Request/response bundle between the blackjack game FSM (master) and the card dealer (slave).
// The master owns shuffle/req; the dealer drives the card pulse, the decoded card and the status.
interface card_dealer_if;
  logic       shuffle;
  logic       req;
  logic       card_valid;
  logic [5:0] card_index;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       busy;
  logic       empty_err;

  modport master (
    output shuffle, req,
    input  card_valid, card_index, card_rank, card_suit, card_value,
    input  cards_left, busy, empty_err
  );

  modport slave (
    input  shuffle, req,
    output card_valid, card_index, card_rank, card_suit, card_value,
    output cards_left, busy, empty_err
  );
endinterface

// File: rtl/card_dealer.sv
// Single-deck card source: draws without replacement using a free-running 6-bit LFSR as the
// candidate generator and a 52-bit used mask; answers each request with a one-cycle card pulse.
module card_dealer #(
  parameter logic [5:0] SEED = 6'h01
) (
  input  logic      Clock,
  input  logic      reset,
  card_dealer_if.slave bus
);

  localparam logic [5:0] SEED_EFF  = (SEED == 6'd0) ? 6'h01 : SEED;
  localparam logic [5:0] DECK_SIZE = 6'd52;

  typedef enum logic [0:0] {IDLE, DRAW} state_t;

  state_t      state, state_n;
  logic [5:0]  lfsr, lfsr_n;
  logic [51:0] used, used_n;
  logic [5:0]  left, left_n;
  logic [5:0]  idx, idx_n;
  logic [3:0]  rank, rank_n;
  logic [1:0]  suit, suit_n;
  logic [3:0]  val, val_n;
  logic        cv, cv_n;
  logic        ee, ee_n;

  // candidate qualification and decode straight from the current LFSR value
  logic [5:0]  cand_idx0;
  logic [63:0] used_pad;
  logic [63:0] cand_bit;
  logic        cand_ok;
  logic [5:0]  r6;
  logic [3:0]  dec_rank;
  logic [1:0]  dec_suit;
  logic [3:0]  dec_val;

  assign cand_idx0 = lfsr - 6'd1;
  assign used_pad  = {12'd0, used};
  assign cand_bit  = 64'd1 << cand_idx0;
  assign cand_ok   = (lfsr != 6'd0) && (lfsr <= DECK_SIZE) && !used_pad[cand_idx0];

  always_comb begin
    r6       = 6'd0;
    dec_suit = 2'd0;
    if (cand_idx0 < 6'd13) begin
      r6       = cand_idx0 + 6'd1;
      dec_suit = 2'd0;
    end else if (cand_idx0 < 6'd26) begin
      r6       = cand_idx0 - 6'd12;
      dec_suit = 2'd1;
    end else if (cand_idx0 < 6'd39) begin
      r6       = cand_idx0 - 6'd25;
      dec_suit = 2'd2;
    end else begin
      r6       = cand_idx0 - 6'd38;
      dec_suit = 2'd3;
    end
    dec_rank = r6[3:0];
    // ace scores 11, face cards score 10
    if (dec_rank == 4'd1)       dec_val = 4'd11;
    else if (dec_rank > 4'd10)  dec_val = 4'd10;
    else                        dec_val = dec_rank;
  end

  always_comb begin
    state_n = state;
    lfsr_n  = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    used_n  = used;
    left_n  = left;
    idx_n   = idx;
    rank_n  = rank;
    suit_n  = suit;
    val_n   = val;
    cv_n    = 1'b0;
    ee_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.shuffle) begin
          used_n = '0;
          left_n = DECK_SIZE;
          lfsr_n = SEED_EFF;
        end else if (bus.req) begin
          if (left == 6'd0) ee_n    = 1'b1;
          else              state_n = DRAW;
        end
      end
      DRAW: begin
        if (bus.shuffle) begin
          used_n  = '0;
          left_n  = DECK_SIZE;
          lfsr_n  = SEED_EFF;
          state_n = IDLE;
        end else if (cand_ok) begin
          used_n  = used | cand_bit[51:0];
          left_n  = left - 6'd1;
          idx_n   = lfsr;
          rank_n  = dec_rank;
          suit_n  = dec_suit;
          val_n   = dec_val;
          cv_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lfsr  <= SEED_EFF;
      used  <= '0;
      left  <= DECK_SIZE;
      idx   <= '0;
      rank  <= '0;
      suit  <= '0;
      val   <= '0;
      cv    <= 1'b0;
      ee    <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_n;
      used  <= used_n;
      left  <= left_n;
      idx   <= idx_n;
      rank  <= rank_n;
      suit  <= suit_n;
      val   <= val_n;
      cv    <= cv_n;
      ee    <= ee_n;
    end
  end

  assign bus.card_valid = cv;
  assign bus.card_index = idx;
  assign bus.card_rank  = rank;
  assign bus.card_suit  = suit;
  assign bus.card_value = val;
  assign bus.cards_left = left;
  assign bus.busy       = (state == DRAW);
  assign bus.empty_err  = ee;

endmodule
